// File: rtl/wb_decode_pkg.sv
// wb_decode_pkg: shared types and constants for the Wishbone data-bus decoder.
//   - wb_state_e : decoder FSM encoding (IDLE, ACCESS, RESP, ERROR)
//   - wb_req_t   : captured master request driven onto the shared slave bus
//   - SEL_*      : byte-lane one-hot constants used by narrow-slave steering
//   - BASE_*     : default ADR[31:16] windows of the DIGITAL_TOP slaves
package wb_decode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERROR  = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
  } wb_req_t;

  localparam logic [3:0] SEL_B0   = 4'b0001;
  localparam logic [3:0] SEL_B1   = 4'b0010;
  localparam logic [3:0] SEL_B2   = 4'b0100;
  localparam logic [3:0] SEL_B3   = 4'b1000;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  localparam logic [15:0] BASE_DATA_RAM    = 16'h0000;
  localparam logic [15:0] BASE_UART_REGS   = 16'hA000;
  localparam logic [15:0] BASE_NEXYS2_REGS = 16'hB000;
  localparam logic [15:0] BASE_EXT_REGS    = 16'hD000;

  // slave 0 in the low 16 bits
  localparam logic [63:0] DEF_SLV_BASE = {BASE_EXT_REGS, BASE_NEXYS2_REGS,
                                          BASE_UART_REGS, BASE_DATA_RAM};
  localparam logic [3:0]  DEF_SLV_NARROW = 4'b0010;

endpackage

// File: rtl/wb_lane_steer.sv
// wb_lane_steer: combinational byte-lane steering for 8-bit (narrow) slaves.
//   i_sel     in  4   master byte lanes
//   i_wdat    in  32  master write word
//   i_rbyte   in  8   narrow slave read byte (its [7:0])
//   o_onehot  out 1   i_sel selects exactly one lane
//   o_adr_lo  out 2   byte offset to put on ADR[1:0]
//   o_wbyte   out 8   write byte taken from the selected lane
//   o_rdat    out 32  read byte placed back into the selected lane
module wb_lane_steer
  import wb_decode_pkg::*;
(
  input  logic [3:0]  i_sel,
  input  logic [31:0] i_wdat,
  input  logic [7:0]  i_rbyte,
  output logic        o_onehot,
  output logic [1:0]  o_adr_lo,
  output logic [7:0]  o_wbyte,
  output logic [31:0] o_rdat
);

  always_comb begin
    o_onehot = 1'b1;
    o_adr_lo = 2'd0;
    o_wbyte  = 8'h00;
    o_rdat   = 32'h0;
    case (i_sel)
      SEL_B0: begin o_adr_lo = 2'd0; o_wbyte = i_wdat[7:0];   o_rdat = {24'h0, i_rbyte};        end
      SEL_B1: begin o_adr_lo = 2'd1; o_wbyte = i_wdat[15:8];  o_rdat = {16'h0, i_rbyte, 8'h0};  end
      SEL_B2: begin o_adr_lo = 2'd2; o_wbyte = i_wdat[23:16]; o_rdat = {8'h0, i_rbyte, 16'h0};  end
      SEL_B3: begin o_adr_lo = 2'd3; o_wbyte = i_wdat[31:24]; o_rdat = {i_rbyte, 24'h0};        end
      default: o_onehot = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_data_decoder.sv
// wb_data_decoder: one Wishbone data master fanned out to NUM_SLV slaves.
// Registered decode, 8/32-bit lane steering, ERR for unmapped / illegal narrow.
// Optional macro WB_DECODE_TIMEOUT_EN: abort ACCESS with ERR after TIMEOUT_CYC
// cycles without ACK; when undefined ACCESS waits forever.
//   CLK, RST_ASYNC_N            clock, async active-low reset
//   M_CYC/STB/ADR/SEL/WE/DAT_WR master request in
//   M_ACK/ERR/DAT_RD_OUT        master response (registered one-cycle pulses)
//   S_CYC/STB_OUT               per-slave one-hot strobe
//   S_ADR/SEL/WE/DAT_WR_OUT     shared slave request (registered)
//   S_ACK_IN, S_DAT_RD_IN       per-slave response, slave i at [32i+:32]
module wb_data_decoder
  import wb_decode_pkg::*;
#(
  parameter int                    NUM_SLV     = 4,
  parameter logic [NUM_SLV*16-1:0] SLV_BASE    = (NUM_SLV*16)'(DEF_SLV_BASE),
  parameter logic [NUM_SLV-1:0]    SLV_NARROW  = NUM_SLV'(DEF_SLV_NARROW),
  parameter int                    TIMEOUT_CYC = 255
) (
  input  logic                    CLK,
  input  logic                    RST_ASYNC_N,
  input  logic                    M_CYC_IN,
  input  logic                    M_STB_IN,
  input  logic [31:0]             M_ADR_IN,
  input  logic [3:0]              M_SEL_IN,
  input  logic                    M_WE_IN,
  input  logic [31:0]             M_DAT_WR_IN,
  output logic                    M_ACK_OUT,
  output logic                    M_ERR_OUT,
  output logic [31:0]             M_DAT_RD_OUT,
  output logic [NUM_SLV-1:0]      S_CYC_OUT,
  output logic [NUM_SLV-1:0]      S_STB_OUT,
  output logic [31:0]             S_ADR_OUT,
  output logic [3:0]              S_SEL_OUT,
  output logic                    S_WE_OUT,
  output logic [31:0]             S_DAT_WR_OUT,
  input  logic [NUM_SLV-1:0]      S_ACK_IN,
  input  logic [NUM_SLV*32-1:0]   S_DAT_RD_IN
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  wb_state_e          r_state, w_nxt;
  wb_req_t            r_req;
  logic [NUM_SLV-1:0] r_stb, w_stb_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx;
  logic               r_narrow, w_hit, w_narrow, w_ack_sel, w_tmo, w_load;
  logic               r_ack, r_err, w_ack_nxt, w_err_nxt;
  logic [31:0]        r_rdat, w_rdat_nxt, w_rword;
  logic [3:0]         w_steer_sel;
  logic               w_onehot;
  logic [1:0]         w_adr_lo;
  logic [7:0]         w_wbyte;
  logic [31:0]        w_steer_rdat;

  // descending scan so the lowest matching index is the one left standing
  always_comb begin
    w_hit    = 1'b0;
    w_idx    = '0;
    w_narrow = 1'b0;
    for (int i = NUM_SLV-1; i >= 0; i--) begin
      if (M_ADR_IN[31:16] == SLV_BASE[16*i +: 16]) begin
        w_hit    = 1'b1;
        w_idx    = IDX_W'(i);
        w_narrow = SLV_NARROW[i];
      end
    end
  end

  // response of the slave captured at accept; other slaves' ACKs never reach here
  always_comb begin
    w_ack_sel = 1'b0;
    w_rword   = 32'h0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_ack_sel = S_ACK_IN[i];
        w_rword   = S_DAT_RD_IN[32*i +: 32];
      end
    end
  end

  // one steering unit: request lanes in IDLE, captured lanes for the read return
  assign w_steer_sel = (r_state == ST_IDLE) ? M_SEL_IN : r_req.sel;

  wb_lane_steer u_steer (
    .i_sel    (w_steer_sel),
    .i_wdat   (M_DAT_WR_IN),
    .i_rbyte  (w_rword[7:0]),
    .o_onehot (w_onehot),
    .o_adr_lo (w_adr_lo),
    .o_wbyte  (w_wbyte),
    .o_rdat   (w_steer_rdat)
  );

`ifdef WB_DECODE_TIMEOUT_EN
  logic [7:0] r_tmo;
  // held at 0 outside ACCESS, so it starts from 0 on every entry
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N)             r_tmo <= 8'd0;
    else if (r_state != ST_ACCESS) r_tmo <= 8'd0;
    else                          r_tmo <= r_tmo + 8'd1;
  end
  // true during the TIMEOUT_CYC-th ACCESS cycle
  assign w_tmo = (r_tmo == 8'(TIMEOUT_CYC - 1));
`else
  assign w_tmo = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) r_state <= ST_IDLE;
    else              r_state <= w_nxt;
  end

  // FSM: next state (abort beats ACK, ACK beats timeout)
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:
        if (M_CYC_IN && M_STB_IN)
          w_nxt = (!w_hit || (w_narrow && !w_onehot)) ? ST_ERROR : ST_ACCESS;
      ST_ACCESS:
        if (!M_CYC_IN)      w_nxt = ST_IDLE;
        else if (w_ack_sel) w_nxt = ST_RESP;
        else if (w_tmo)     w_nxt = ST_ERROR;
      ST_RESP:  w_nxt = ST_IDLE;
      ST_ERROR: w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs, computed one cycle early so every port is a flop
  always_comb begin
    w_load     = 1'b0;
    w_stb_nxt  = '0;
    w_ack_nxt  = 1'b0;
    w_err_nxt  = 1'b0;
    w_rdat_nxt = 32'h0;
    case (w_nxt)
      ST_ACCESS:
        if (r_state == ST_IDLE) begin
          w_load = 1'b1;
          for (int i = 0; i < NUM_SLV; i++) w_stb_nxt[i] = (w_idx == IDX_W'(i));
        end else begin
          w_stb_nxt = r_stb;
        end
      ST_RESP: begin
        w_ack_nxt = 1'b1;
        if (!r_req.we) w_rdat_nxt = r_narrow ? w_steer_rdat : w_rword;
      end
      ST_ERROR: w_err_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      r_stb  <= '0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_rdat <= 32'h0;
    end else begin
      r_stb  <= w_stb_nxt;
      r_ack  <= w_ack_nxt;
      r_err  <= w_err_nxt;
      r_rdat <= w_rdat_nxt;
    end
  end

  // request capture; narrow slaves see the byte offset and the byte on [7:0]
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      r_req    <= '0;
      r_idx    <= '0;
      r_narrow <= 1'b0;
    end else if (w_load) begin
      r_req.adr <= {M_ADR_IN[31:2], (w_narrow ? w_adr_lo : 2'b00)};
      r_req.sel <= M_SEL_IN;
      r_req.we  <= M_WE_IN;
      r_req.dat <= w_narrow ? {24'h0, w_wbyte} : M_DAT_WR_IN;
      r_idx     <= w_idx;
      r_narrow  <= w_narrow;
    end
  end

  assign M_ACK_OUT    = r_ack;
  assign M_ERR_OUT    = r_err;
  assign M_DAT_RD_OUT = r_rdat;
  assign S_CYC_OUT    = r_stb;
  assign S_STB_OUT    = r_stb;
  assign S_ADR_OUT    = r_req.adr;
  assign S_SEL_OUT    = r_req.sel;
  assign S_WE_OUT     = r_req.we;
  assign S_DAT_WR_OUT = r_req.dat;

endmodule

// File: tb/tb_wb_data_decoder.sv
// tb_wb_data_decoder: random and directed transfers against a small decode
// model; slave 3 aliases the UART window to exercise lowest-index priority.
module tb_wb_data_decoder;

  localparam int          NS  = 4;
  localparam int          TMO = 255;
  localparam logic [63:0] BASES  = {16'hA000, 16'hB000, 16'hA000, 16'h0000};
  localparam logic [3:0]  NARROW = 4'b0010;

  // model view of the same map
  logic [15:0] base_t   [NS] = '{16'h0000, 16'hA000, 16'hB000, 16'hA000};
  bit          narrow_t [NS] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic CLK = 1'b0;
  logic RST_ASYNC_N = 1'b0;
  logic M_CYC_IN = 1'b0, M_STB_IN = 1'b0, M_WE_IN = 1'b0;
  logic [31:0] M_ADR_IN = '0, M_DAT_WR_IN = '0;
  logic [3:0]  M_SEL_IN = '0;
  logic        M_ACK_OUT, M_ERR_OUT, S_WE_OUT;
  logic [31:0] M_DAT_RD_OUT, S_ADR_OUT, S_DAT_WR_OUT;
  logic [NS-1:0] S_CYC_OUT, S_STB_OUT, S_ACK_IN;
  logic [3:0]  S_SEL_OUT;
  logic [NS*32-1:0] S_DAT_RD_IN;

  logic [31:0]   slv_rd [NS];
  int            ack_wait = 0;
  bit            no_ack = 1'b0;
  logic [NS-1:0] noise = '0;
  int            stb_cnt = 0;
  int            n_chk = 0, n_pass = 0;
  logic [31:0]   last_sadr, last_sdat, last_rd;

  wb_data_decoder #(.NUM_SLV(NS), .SLV_BASE(BASES), .SLV_NARROW(NARROW),
                    .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N),
    .M_CYC_IN(M_CYC_IN), .M_STB_IN(M_STB_IN), .M_ADR_IN(M_ADR_IN),
    .M_SEL_IN(M_SEL_IN), .M_WE_IN(M_WE_IN), .M_DAT_WR_IN(M_DAT_WR_IN),
    .M_ACK_OUT(M_ACK_OUT), .M_ERR_OUT(M_ERR_OUT), .M_DAT_RD_OUT(M_DAT_RD_OUT),
    .S_CYC_OUT(S_CYC_OUT), .S_STB_OUT(S_STB_OUT), .S_ADR_OUT(S_ADR_OUT),
    .S_SEL_OUT(S_SEL_OUT), .S_WE_OUT(S_WE_OUT), .S_DAT_WR_OUT(S_DAT_WR_OUT),
    .S_ACK_IN(S_ACK_IN), .S_DAT_RD_IN(S_DAT_RD_IN)
  );

  always #5 CLK = ~CLK;

  // slave model: strobed slave acks after ack_wait cycles; others may ack as noise
  always_comb begin
    for (int i = 0; i < NS; i++) S_DAT_RD_IN[32*i +: 32] = slv_rd[i];
    S_ACK_IN = (no_ack ? '0 : (S_STB_OUT & {NS{stb_cnt >= ack_wait}})) | (noise & ~S_STB_OUT);
  end

  always @(posedge CLK) stb_cnt <= (|S_STB_OUT) ? stb_cnt + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic [31:0] adr, input logic [3:0] sel, input bit we,
                       input logic [31:0] wdat);
    @(negedge CLK);
    M_CYC_IN = 1'b1; M_STB_IN = 1'b1;
    M_ADR_IN = adr; M_SEL_IN = sel; M_WE_IN = we; M_DAT_WR_IN = wdat;
  endtask

  task automatic release_bus();
    @(negedge CLK);
    M_CYC_IN = 1'b0; M_STB_IN = 1'b0; M_ADR_IN = '0; M_SEL_IN = '0;
    M_WE_IN = 1'b0; M_DAT_WR_IN = '0;
  endtask

  // full transfer with expectations derived from the address map and lane rules
  task automatic xfer(input logic [31:0] adr, input logic [3:0] sel, input bit we,
                      input logic [31:0] wdat, input int wt);
    int slv, lane;
    bit err, nar;
    logic [31:0] e_adr, e_wd, e_rd;
    logic [NS-1:0] e_stb;
    slv = -1;
    for (int i = 0; i < NS; i++) if (slv < 0 && base_t[i] == adr[31:16]) slv = i;
    lane = 0;
    for (int b = 0; b < 4; b++) if (sel[b]) lane = b;
    nar = (slv >= 0) ? narrow_t[slv] : 1'b0;
    err = (slv < 0) || (nar && $countones(sel) != 1);
    e_stb = '0; e_adr = '0; e_wd = '0; e_rd = '0;
    if (!err) begin
      e_stb = NS'(1) << slv;
      if (nar) begin
        e_adr = {adr[31:2], 2'(lane)};
        e_wd  = (wdat >> (8*lane)) & 32'hFF;
        e_rd  = (slv_rd[slv] & 32'hFF) << (8*lane);
      end else begin
        e_adr = {adr[31:2], 2'b00};
        e_wd  = wdat;
        e_rd  = slv_rd[slv];
      end
      if (we) e_rd = 32'h0;
    end
    ack_wait = wt;
    drive(adr, sel, we, wdat);
    @(posedge CLK); #1;
    if (err) begin
      chk("err_pulse", 32'(M_ERR_OUT), 32'd1);
      chk("err_nostb", 32'({S_CYC_OUT, S_STB_OUT, M_ACK_OUT}), 32'd0);
      chk("err_rd", M_DAT_RD_OUT, 32'h0);
    end else begin
      chk("s_stb", 32'({S_CYC_OUT, S_STB_OUT}), 32'({e_stb, e_stb}));
      chk("s_adr", S_ADR_OUT, e_adr);
      chk("s_dat", S_DAT_WR_OUT, e_wd);
      chk("s_we_sel", 32'({S_WE_OUT, S_SEL_OUT}), 32'({we, sel}));
      last_sadr = S_ADR_OUT; last_sdat = S_DAT_WR_OUT;
      for (int k = 0; k < wt; k++) begin
        @(posedge CLK); #1;
        chk("wait_hold", 32'({M_ACK_OUT, M_ERR_OUT, S_STB_OUT}), 32'({2'b00, e_stb}));
      end
      @(posedge CLK); #1;
      chk("m_ack", 32'({M_ERR_OUT, M_ACK_OUT, S_STB_OUT}), 32'({2'b01, {NS{1'b0}}}));
      chk("m_rd", M_DAT_RD_OUT, e_rd);
      last_rd = M_DAT_RD_OUT;
    end
    // strobe still held through RESP/ERROR: must not start another access
    @(posedge CLK); #1;
    chk("post_idle", 32'({M_ACK_OUT, M_ERR_OUT, S_STB_OUT}), 32'd0);
    chk("post_rd", M_DAT_RD_OUT, 32'h0);
    release_bus();
  endtask

  initial begin
    int n;
    logic [31:0] tmp;
    logic [15:0] up;
    for (int i = 0; i < NS; i++) slv_rd[i] = $urandom;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_m", 32'({M_ACK_OUT, M_ERR_OUT, S_CYC_OUT, S_STB_OUT}), 32'd0);
    chk("rst_rd", M_DAT_RD_OUT, 32'h0);
    @(negedge CLK); RST_ASYNC_N = 1'b1;

    // 1: wide write to RAM, zero wait
    xfer(32'h0000_0010, 4'hF, 1'b1, 32'h1234_5678, 0);
    chk("t1_dat", last_sdat, 32'h1234_5678);
    // 2: narrow read from UART lane 2
    slv_rd[1] = 32'hFFFF_FF5A;
    xfer(32'hA000_1004, 4'b0100, 1'b0, 32'h0, 0);
    chk("t2_adr", 32'(last_sadr[2:0]), 32'd6);
    chk("t2_rd", last_rd, 32'h005A_0000);
    // 3: unmapped, 4: narrow with two lanes
    xfer(32'hC000_0000, 4'hF, 1'b0, 32'h0, 0);
    xfer(32'hA000_0000, 4'b0011, 1'b1, 32'hDEAD_BEEF, 0);

    // random traffic with random wait states and stray ACKs
    for (int t = 0; t < 60; t++) begin
      tmp = $urandom;
      case ($urandom_range(0, 4))
        0: up = 16'h0000;
        1: up = 16'hA000;
        2: up = 16'hB000;
        3: up = 16'hC000;
        default: up = tmp[31:16];
      endcase
      for (int i = 0; i < NS; i++) slv_rd[i] = $urandom;
      noise = NS'($urandom);
      xfer({up, tmp[15:0]}, 4'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3));
    end
    noise = '0;

    // 5: slave 2 never acks
    no_ack = 1'b1;
    drive(32'hB000_0020, 4'hF, 1'b0, 32'h0);
    @(posedge CLK); #1;
    chk("t5_stb", 32'(S_STB_OUT), 32'b0100);
    n = 0;
    while (!M_ERR_OUT && n < 1000) begin @(posedge CLK); #1; n++; end
`ifdef WB_DECODE_TIMEOUT_EN
    chk("t5_tmo_cyc", 32'(n), 32'(TMO));
    chk("t5_tmo_err", 32'({M_ERR_OUT, M_ACK_OUT, S_STB_OUT}), 32'({2'b10, {NS{1'b0}}}));
    release_bus();
`else
    chk("t5_wait", 32'({M_ERR_OUT, M_ACK_OUT, S_STB_OUT}), 32'b0100);
    release_bus();
    @(posedge CLK); #1;
    chk("t5_abort", 32'({M_ERR_OUT, M_ACK_OUT, S_STB_OUT}), 32'd0);
`endif
    @(posedge CLK);

    // 6a: async reset mid-ACCESS
    drive(32'hB000_0000, 4'hF, 1'b1, 32'hCAFE_F00D);
    @(posedge CLK); #1;
    chk("t6_stb", 32'(S_STB_OUT), 32'b0100);
    @(posedge CLK); #2;
    RST_ASYNC_N = 1'b0;
    #1;
    chk("t6_rst_m", 32'({M_ACK_OUT, M_ERR_OUT, S_CYC_OUT, S_STB_OUT, S_WE_OUT, S_SEL_OUT}), 32'd0);
    chk("t6_rst_adr", S_ADR_OUT, 32'h0);
    chk("t6_rst_dat", S_DAT_WR_OUT | M_DAT_RD_OUT, 32'h0);
    release_bus();
    RST_ASYNC_N = 1'b1;
    @(posedge CLK); #1;
    chk("t6_rst_idle", 32'({M_ACK_OUT, M_ERR_OUT, S_STB_OUT}), 32'd0);

    // 6b: master drops CYC mid-ACCESS
    drive(32'h0000_0040, 4'hF, 1'b0, 32'h0);
    @(posedge CLK); #1;
    chk("t6_ab_stb", 32'(S_STB_OUT), 32'b0001);
    repeat (2) @(posedge CLK);
    release_bus();
    @(posedge CLK); #1;
    chk("t6_ab_clr", 32'({M_ACK_OUT, M_ERR_OUT, S_CYC_OUT, S_STB_OUT}), 32'd0);
    @(posedge CLK); #1;
    chk("t6_ab_quiet", 32'({M_ACK_OUT, M_ERR_OUT, S_STB_OUT}), 32'd0);
    no_ack = 1'b0;

    // back to normal after abort
    slv_rd[0] = 32'h0BAD_F00D;
    xfer(32'h0000_0044, 4'hF, 1'b0, 32'h0, 1);
    chk("t6_after", last_rd, 32'h0BAD_F00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
